// File: rtl/pc_pkg.sv
// Shared encodings for the next-PC select path: the mux select values
// and the sequencer state encoding. Both the sequencer and the mux
// decode import this package so the select encoding has one definition.
package pc_pkg;

    localparam logic [1:0] SEL_INCR   = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_STEP   = 2'b10,
        ST_HALTED = 2'b11
    } state_e;

    // Branch beats jump: the branch belongs to the older instruction.
    function automatic logic [1:0] select_of(input logic branch_taken, input logic jump);
        logic [1:0] sel;
        if (branch_taken) begin
            sel = SEL_BRANCH;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else begin
            sel = SEL_INCR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear. Holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_clear,
    input  logic                 i_enable,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_r;

    // Clear dominates; otherwise count up while enabled until saturated.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            count_r <= {CNT_WIDTH{1'b0}};
        end else if (i_enable && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end
    end

    assign o_count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Control end of the next-PC path: owns the PC register, drives the
// next-PC mux select, gates PC advance on debug run/step, hazard stall
// and HALT, and parks redirects that arrive while the PC is held.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                     DATA_WIDTH = 32,
    parameter int unsigned            PC_STEP    = 4,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0,
    parameter int                     CNT_WIDTH  = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_step,
    input  logic                  i_stall,
    input  logic                  i_branch_taken,
    input  logic                  i_jump,
    input  logic                  i_halt_fetched,
    input  logic [DATA_WIDTH-1:0] i_pc_next,
    output logic [DATA_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_pc_incr,
    output logic [1:0]            o_select,
    output logic                  o_pc_write,
    output logic                  o_halted,
    output logic [CNT_WIDTH-1:0]  o_cycle_count
);

    localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(PC_STEP);

    state_e                state_r;
    logic [DATA_WIDTH-1:0] pc_r;
    logic [DATA_WIDTH-1:0] pending_pc_r;
    logic                  pending_r;
    logic                  halted_r;

    logic                  active_s;
    logic                  advance_s;
    logic                  redirect_s;
    logic                  halt_take_s;
    logic                  pc_write_s;
    logic [1:0]            select_s;

    // Advance/halt qualification and mux select for the current cycle.
    always_comb begin
        active_s    = 1'b0;
        advance_s   = 1'b0;
        redirect_s  = i_branch_taken | i_jump;
        halt_take_s = 1'b0;
        pc_write_s  = 1'b0;
        select_s    = select_of(i_branch_taken, i_jump);
        if ((state_r == ST_RUN) || (state_r == ST_STEP)) begin
            active_s = 1'b1;
        end else begin
            active_s = 1'b0;
        end
        advance_s = active_s & ~i_stall;
        // A redirect or parked redirect means the HALT is on the wrong path.
        if (advance_s && i_halt_fetched && !redirect_s && !pending_r) begin
            halt_take_s = 1'b1;
        end else begin
            halt_take_s = 1'b0;
        end
        pc_write_s = advance_s & ~halt_take_s;
    end

    // Sequencer FSM together with the PC, parked-redirect and halt registers.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            pc_r         <= RESET_PC;
            pending_r    <= 1'b0;
            pending_pc_r <= {DATA_WIDTH{1'b0}};
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_start) begin
                        state_r <= ST_RUN;
                    end else if (i_step) begin
                        state_r <= ST_STEP;
                    end
                    halted_r <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_take_s) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                ST_STEP: begin
                    if (halt_take_s) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else if (advance_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    halted_r <= 1'b0;
                end
            endcase

            if (pc_write_s) begin
                pc_r <= pending_r ? pending_pc_r : i_pc_next;
            end

            // A parked redirect is consumed by the next PC write; new
            // requests while one is parked are dropped (upstream repeats them).
            if (pc_write_s && pending_r) begin
                pending_r <= 1'b0;
            end else if (redirect_s && !advance_s && !pending_r) begin
                pending_r    <= 1'b1;
                pending_pc_r <= i_pc_next;
            end
        end
    end

    sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_cycle_counter (
        .i_clock  (i_clock),
        .i_clear  (i_reset),
        .i_enable (active_s),
        .o_count  (o_cycle_count)
    );

    assign o_pc       = pc_r;
    assign o_pc_incr  = pc_r + STEP_W;
    assign o_select   = select_s;
    assign o_pc_write = pc_write_s;
    assign o_halted   = halted_r;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Control end of the next-PC select path. Owns the PC register, drives the 2-bit select into the next-PC mux, generates PC+step for the mux incr input, and registers the mux result back as the new PC.
- Gates PC advance on three things: debug run/step commands, the hazard-unit stall, and HALT detection.
- Latches redirects that arrive while the PC cannot advance, so a branch or jump is never lost.

Parameters:
- DATA_WIDTH, 32, PC and target width.
- PC_STEP, 4, increment added to PC for o_pc_incr.
- RESET_PC, 0, PC value after reset.
- CNT_WIDTH, 32, width of the active-cycle counter.

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  debug: enter continuous run.
- i_step  input  1  debug: advance exactly one PC update.
- i_stall  input  1  hazard unit: hold PC this cycle.
- i_branch_taken  input  1  branch resolved taken.
- i_jump  input  1  jump decoded.
- i_halt_fetched  input  1  instruction at o_pc is HALT.
- i_pc_next  input  DATA_WIDTH  next-PC mux output.
- o_pc  output  DATA_WIDTH  current PC.
- o_pc_incr  output  DATA_WIDTH  o_pc + PC_STEP, combinational, to mux incr input.
- o_select  output  2  mux select: 00 incr, 01 branch, 10 jump; 11 is never driven.
- o_pc_write  output  1  PC updates this cycle; also IF/ID write enable.
- o_halted  output  1  sequencer in HALTED.
- o_cycle_count  output  CNT_WIDTH  cycles spent in RUN or STEP.

Behaviour:
- Reset (synchronous, dominates everything):
  - state = IDLE, o_pc = RESET_PC, pending cleared, o_cycle_count = 0, o_halted = 0.
  - A reset mid-run or mid-stall discards any pending redirect.
- States: IDLE, RUN, STEP, HALTED.
  - IDLE: i_start goes to RUN; else i_step goes to STEP. If both are asserted, i_start wins.
  - RUN: stays in RUN until a HALT is taken.
  - STEP: returns to IDLE on the cycle that advance occurs. While stalled, remains in STEP.
  - HALTED: terminal until reset. o_halted = 1.
- advance = (state == RUN or state == STEP) and not i_stall. o_pc_write = advance.
- o_select, combinational:
  - 01 if i_branch_taken; else 10 if i_jump; else 00.
  - Branch beats jump, because the branch belongs to the older instruction.
- PC update when advance:
  - pending set: o_pc <= pending_pc.
  - else: o_pc <= i_pc_next.
  - Latency is one cycle from select to PC.
- Pending redirect:
  - Capture: when (i_branch_taken or i_jump) and not advance and pending clear, capture pending_pc <= i_pc_next and set pending.
  - While pending is set, further requests are ignored; a stalled upstream stage repeats the same request.
  - Cleared on the advance that consumes it.
  - Capture is also allowed in IDLE between steps.
- HALT:
  - On advance with i_halt_fetched = 1, no redirect and no pending: o_pc holds, state goes to HALTED, and o_pc_write is forced to 0 that cycle.
  - If a redirect or pending is present, it wins and HALT is ignored (wrong-path instruction).
  - i_halt_fetched while stalled has no effect.
- Cycle counter: increments each cycle in RUN or STEP, including stalled cycles. Saturates at all-ones. Frozen in IDLE and HALTED.
- Arithmetic: o_pc_incr wraps modulo 2^DATA_WIDTH, no overflow flag.
- Invalid state encoding: recovers to IDLE on the next clock.

Decomposition:
- Shared package `pc_pkg`:
  - Select encodings SEL_INCR = 2'b00, SEL_BRANCH = 2'b01, SEL_JUMP = 2'b10.
  - State encodings ST_IDLE, ST_RUN, ST_STEP, ST_HALTED.
- The select encodings must match the mux decode; both sides import the package.
- One sub-module, `sat_counter`: a CNT_WIDTH saturating counter with enable and synchronous clear. The FSM, pending register and PC register stay in pc_sequencer.

Test Plan:
- Reset, i_start, no stall, mux fed incr -> o_pc 0, 4, 8, 12 on successive cycles; o_select = 00; o_pc_write = 1 from the first RUN cycle.
- RUN at PC = 0x10, i_branch_taken and i_jump both high, i_pc_next = 0x80 -> o_select = 01; o_pc = 0x80 next cycle.
- i_stall high for 3 cycles while i_jump pulses for 1 cycle with i_pc_next = 0x200 -> PC holds; on stall release o_pc = 0x200; pending cleared.
- IDLE at 0x20, i_step pulse with i_stall high for 2 cycles -> PC advances to 0x24 exactly once after the stall drops; state returns to IDLE; counter = 3.
- RUN, i_halt_fetched at PC = 0x40 with no redirect -> PC stays 0x40; o_halted = 1; o_pc_write = 0; counter frozen. Repeat with i_branch_taken high in the same cycle -> branch taken, no halt.
- Assert i_reset during a pending redirect in STEP -> next cycle o_pc = RESET_PC, IDLE, pending cleared, counter = 0.
